// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the sized data-memory block.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'd1;
            SZ_HALF: return 4'd2;
            SZ_WORD: return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational size/alignment checker, big-endian store lane builder and load extender.
// raw_bytes/wr_bytes carry RAM[a+k] in bits [63-8k -: 8].
module dmem_align
    import dmem_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [1:0]           size,
    input  logic                 ld_signed,
    input  logic [2:0]           addr_lo,
    input  logic [63:0]          raw_bytes,
    input  logic [DataWidth-1:0] wdata,
    output logic                 err,
    output logic [7:0]           wr_mask,
    output logic [63:0]          wr_bytes,
    output logic [DataWidth-1:0] ld_value
);

    logic [3:0]  nb;
    logic [6:0]  sh;
    logic [63:0] wdata_w;

    // Right-justify a left-aligned byte window, optionally replicating its MSB.
    function automatic logic [63:0] extend(input logic [63:0] window,
                                           input logic [6:0]  shamt,
                                           input logic        sx);
        logic signed [63:0] s_window;
        s_window = $signed(window);
        if (sx) return s_window >>> shamt;
        return window >> shamt;
    endfunction

    assign nb      = size_bytes(size);
    assign sh      = 7'd64 - 7'({nb, 3'b000});
    assign wdata_w = 64'(wdata);

    always_comb begin
        unique case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr_lo[0];
            SZ_WORD: err = |addr_lo[1:0];
            default: err = (|addr_lo) || (DataWidth == 32);
        endcase
    end

    // Left-justifying the store data puts its most significant byte at RAM[a].
    assign wr_bytes = wdata_w << sh;
    assign wr_mask  = err ? 8'h00 : (8'hFF >> (4'd8 - nb));
    assign ld_value = err ? '0 : DataWidth'(extend(raw_bytes, sh, ld_signed));

endmodule

// File: rtl/dmem_sized.sv
// Byte-addressed big-endian data memory with sized loads/stores, valid/ready
// handshakes and a fixed programmable response latency.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int AddrSize  = 16,
    parameter int DataWidth = 32,
    parameter int Latency   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_err
);

    localparam logic [2:0] LatLast = 3'(Latency - 1);

    logic [7:0]           mem [2**AddrSize];
    state_t               state;
    logic [2:0]           lat_cnt;
    logic [AddrSize-1:0]  base;
    logic [63:0]          raw_bytes;
    logic [63:0]          wr_bytes;
    logic [7:0]           wr_mask;
    logic                 acc_err;
    logic [DataWidth-1:0] ld_value;
    logic [DataWidth-1:0] load_res;
    logic                 accept;
    logic                 wr_en;
    logic [DataWidth-1:0] rdata_p0;
    logic                 err_p0;

    assign base      = req_addr[AddrSize-1:0];
    assign req_ready = reset_n && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_we && !acc_err;
    assign load_res  = req_we ? '0 : ld_value;

    generate
        if (AddrSize < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[31:AddrSize];
        end
    endgenerate

    // Eight-byte window starting at the request address, wrapping in the array.
    always_comb begin
        raw_bytes = '0;
        for (int k = 0; k < 8; k++) begin
            raw_bytes[63-8*k -: 8] = mem[base + AddrSize'(k)];
        end
    end

    dmem_align #(
        .DataWidth(DataWidth)
    ) u_align (
        .size      (req_size),
        .ld_signed (req_signed),
        .addr_lo   (req_addr[2:0]),
        .raw_bytes (raw_bytes),
        .wdata     (req_wdata),
        .err       (acc_err),
        .wr_mask   (wr_mask),
        .wr_bytes  (wr_bytes),
        .ld_value  (ld_value)
    );

    // Stores commit at the accept edge; RAM is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                if (wr_mask[k]) mem[base + AddrSize'(k)] <= wr_bytes[63-8*k -: 8];
            end
        end
    end

    // Accept stage: hold the load result/error until the latency expires.
    always_ff @(posedge clk) begin
        if (accept) begin
            rdata_p0 <= load_res;
            err_p0   <= acc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (Latency == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= load_res;
                            rsp_err   <= acc_err;
                        end else begin
                            state   <= WAIT;
                            lat_cnt <= 3'd1;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == LatLast) begin
                        state     <= RESP;
                        lat_cnt   <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_p0;
                        rsp_err   <= err_p0;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sized.sv
// Directed and randomized bench for dmem_sized against a byte-array reference model.
module tb_dmem_sized;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] m [65536];

    dmem_sized #(
        .AddrSize (AW),
        .DataWidth(DW),
        .Latency  (LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: N-byte big-endian access on a flat byte array.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er);
        int     n;
        int     a;
        longint v;
        n  = 1 << sz;
        a  = int'(addr % 32'd65536);
        er = ((addr % n) != 0) || (n * 8 > DW);
        rd = '0;
        if (er) return;
        if (we) begin
            for (int k = 0; k < n; k++) m[(a + k) % 65536] = 8'(wd >> (8 * (n - 1 - k)));
        end else begin
            v = 0;
            for (int k = 0; k < n; k++) v = v * 256 + longint'(m[(a + k) % 65536]);
            if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            rd = 32'(v);
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic stable);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd; rsp_ready = (stall == 0);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = k; break; end
        end
        rd = rsp_rdata; er = rsp_err; stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (rsp_rdata !== rd || rsp_err !== er || rsp_valid !== 1'b1) stable = 1'b0;
        end
        rsp_ready = 1'b1;
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, input int stall,
                       output logic [31:0] rd);
        logic [31:0] erd;
        logic        eer;
        logic        er;
        int          lat;
        logic        stable;
        model(we, sz, sg, addr, wd, erd, eer);
        xact(we, sz, sg, addr, wd, stall, rd, er, lat, stable);
        chk({tag, ".rdata"}, 64'(rd), 64'(erd));
        chk({tag, ".err"}, 64'(er), 64'(eer));
        chk({tag, ".lat"}, 64'(lat), 64'(LAT));
        chk({tag, ".stable"}, 64'(stable), 64'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  sz;
        logic [31:0] addr;
        int          n;

        reset_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_signed = 1'b0; req_addr = 32'h0200; req_wdata = 32'h11223344; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.ready", 64'(req_ready), 64'd0);
            chk("rst.valid", 64'(rsp_valid), 64'd0);
            chk("rst.rdata", 64'(rsp_rdata), 64'd0);
            chk("rst.err",   64'(rsp_err),   64'd0);
        end
        reset_n = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst.ready", 64'(req_ready), 64'd1);

        // A store presented during reset must not reach the array.
        run("st200", 1'b1, 2'b10, 1'b0, 32'h0200, 32'hCAFEF00D, 0, rd);
        @(negedge clk);
        reset_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
        req_addr = 32'h0200; req_wdata = 32'h11223344;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst2.ready", 64'(req_ready), 64'd0);
        end
        reset_n = 1'b1; req_valid = 1'b0;
        run("ld200", 1'b0, 2'b10, 1'b0, 32'h0200, 32'h0, 0, rd);
        chk("ld200.const", 64'(rd), 64'hCAFEF00D);

        run("stw100", 1'b1, 2'b10, 1'b0, 32'h0100, 32'hDEADBEEF, 0, rd);
        run("ldb100", 1'b0, 2'b00, 1'b0, 32'h0100, 32'h0, 0, rd); chk("ldb100.c", 64'(rd), 64'hDE);
        run("ldb101", 1'b0, 2'b00, 1'b0, 32'h0101, 32'h0, 1, rd); chk("ldb101.c", 64'(rd), 64'hAD);
        run("ldb102", 1'b0, 2'b00, 1'b0, 32'h0102, 32'h0, 0, rd); chk("ldb102.c", 64'(rd), 64'hBE);
        run("ldb103", 1'b0, 2'b00, 1'b0, 32'h0103, 32'h0, 0, rd); chk("ldb103.c", 64'(rd), 64'hEF);
        run("ldsb100", 1'b0, 2'b00, 1'b1, 32'h0100, 32'h0, 0, rd); chk("ldsb100.c", 64'(rd), 64'hFFFFFFDE);

        run("sth102", 1'b1, 2'b01, 1'b0, 32'h0102, 32'h1234, 0, rd);
        run("ldw100", 1'b0, 2'b10, 1'b0, 32'h0100, 32'h0, 0, rd); chk("ldw100.c", 64'(rd), 64'hDEAD1234);
        run("sth104", 1'b1, 2'b01, 1'b0, 32'h0104, 32'h8001, 0, rd);
        run("ldsh104", 1'b0, 2'b01, 1'b1, 32'h0104, 32'h0, 0, rd); chk("ldsh104.c", 64'(rd), 64'hFFFF8001);
        run("lduh104", 1'b0, 2'b01, 1'b0, 32'h0104, 32'h0, 0, rd); chk("lduh104.c", 64'(rd), 64'h00008001);

        run("ldw101", 1'b0, 2'b10, 1'b0, 32'h0101, 32'h0, 0, rd);
        run("stw102", 1'b1, 2'b10, 1'b0, 32'h0102, 32'h55667788, 0, rd);
        run("ldw100b", 1'b0, 2'b10, 1'b0, 32'h0100, 32'h0, 0, rd); chk("ldw100b.c", 64'(rd), 64'hDEAD1234);
        run("ldd100", 1'b0, 2'b11, 1'b0, 32'h0100, 32'h0, 0, rd);
        run("std100", 1'b1, 2'b11, 1'b0, 32'h0100, 32'h99999999, 0, rd);
        run("ldw100c", 1'b0, 2'b10, 1'b0, 32'h0100, 32'h0, 0, rd); chk("ldw100c.c", 64'(rd), 64'hDEAD1234);

        // Stalled response: consumer holds rsp_ready low for five cycles.
        @(negedge clk);
        chk("stall.ready0", 64'(req_ready), 64'd1);
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
        req_signed = 1'b0; req_addr = 32'h0100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("stall.ready", 64'(req_ready), 64'd0);
            chk("stall.valid", 64'(rsp_valid), 64'(k >= LAT));
            if (k >= LAT) begin
                chk("stall.rdata", 64'(rsp_rdata), 64'hDEAD1234);
                chk("stall.err", 64'(rsp_err), 64'd0);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall.done_valid", 64'(rsp_valid), 64'd0);
        chk("stall.done_ready", 64'(req_ready), 64'd1);

        run("stwFFFC", 1'b1, 2'b10, 1'b0, 32'h0000FFFC, 32'hA1B2C3D4, 0, rd);
        run("ldb1FFFF", 1'b0, 2'b00, 1'b0, 32'h0001FFFF, 32'h0, 0, rd); chk("ldb1FFFF.c", 64'(rd), 64'hD4);
        run("ldw3FFFC", 1'b0, 2'b10, 1'b0, 32'h0003FFFC, 32'h0, 1, rd); chk("ldw3FFFC.c", 64'(rd), 64'hA1B2C3D4);

        // Reset while the access is still counting down its latency.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_addr = 32'h0100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstwait.valid", 64'(rsp_valid), 64'd0);
        chk("rstwait.ready", 64'(req_ready), 64'd0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstwait.valid_r", 64'(rsp_valid), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstwait.ready_after", 64'(req_ready), 64'd1);
            chk("rstwait.valid_after", 64'(rsp_valid), 64'd0);
        end

        for (int i = 0; i < 64; i++) begin
            run("init", 1'b1, 2'b00, 1'b0, 32'(i), $urandom, 0, rd);
        end
        for (int i = 0; i < 150; i++) begin
            sz = 2'($urandom_range(0, 3));
            n  = 1 << sz;
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7) addr = addr & ~32'(n - 1);
            if (($urandom_range(0, 3) == 0) && (n <= 4)) addr = addr & 32'(64 - n);
            addr = addr | ($urandom << 16);
            run("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
                $urandom, int'($urandom_range(0, 2)), rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
